// File: rtl/race_pkg.sv
// Shared game-flow encodings for the race controller, engines and input encoder.
// Also holds the rectangle hit-test used for finish and checkpoint zones.
package race_pkg;

  typedef enum logic [2:0] {
    MENU      = 3'd0,
    READY     = 3'd1,
    COUNTDOWN = 3'd2,
    PAUSE     = 3'd3,
    RACING    = 3'd4,
    FINISH    = 3'd5
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;
  localparam logic [1:0] WIN_TIE  = 2'd3;

  localparam int CS_PER_SEC = 100;

  // Bounds arrive as arguments so a zero lower bound is an ordinary compare.
  function automatic logic in_rect(input logic [9:0] px, input logic [9:0] py,
                                   input logic [9:0] x0, input logic [9:0] x1,
                                   input logic [9:0] y0, input logic [9:0] y1);
    return (px >= x0) && (px <= x1) && (py >= y0) && (py <= y1);
  endfunction

endpackage

// File: rtl/race_controller_lap_tracker.sv
// Per-player lap counter: a lap needs the checkpoint first, then a fresh entry
// into the finish zone. lap_event is combinational so the top can act on that edge.
module lap_tracker
  import race_pkg::*;
#(
  parameter int LAPS   = 3,
  parameter int FIN_X0 = 0,
  parameter int FIN_X1 = 40,
  parameter int FIN_Y0 = 120,
  parameter int FIN_Y1 = 130,
  parameter int CP_X0  = 260,
  parameter int CP_X1  = 319,
  parameter int CP_Y0  = 100,
  parameter int CP_Y1  = 140
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       clear,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [1:0] lap,
  output logic       lap_event
);

  logic in_fin;
  logic in_cp;
  logic armed;
  logic prev_in_fin;

  assign in_fin = in_rect(x, y, 10'(FIN_X0), 10'(FIN_X1), 10'(FIN_Y0), 10'(FIN_Y1));
  assign in_cp  = in_rect(x, y, 10'(CP_X0), 10'(CP_X1), 10'(CP_Y0), 10'(CP_Y1));

  assign lap_event = enable && in_fin && !prev_in_fin && armed && (lap != 2'(LAPS));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      lap         <= '0;
      armed       <= 1'b0;
      prev_in_fin <= 1'b0;
    end else if (enable) begin
      prev_in_fin <= in_fin;
      if (lap_event) begin
        lap   <= lap + 2'd1;
        armed <= 1'b0;
      end else if (in_cp) begin
        armed <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/race_controller.sv
// Game-flow FSM: menu, respawn hold, countdown, race, pause, finish; lap tracking
// and centisecond race timer. Optional RACE_TIMEOUT_EN forces FINISH at MAX_RACE_CS.
module race_controller
  import race_pkg::*;
#(
  parameter int TICK_DIV   = 1_000_000,
  parameter int LAPS       = 3,
  parameter int HOLD_TICKS = 100,
  parameter int COUNT_SEC  = 3,
  parameter int FIN_X0     = 0,
  parameter int FIN_X1     = 40,
  parameter int FIN_Y0     = 120,
  parameter int FIN_Y1     = 130,
  parameter int CP_X0      = 260,
  parameter int CP_X1      = 319,
  parameter int CP_Y0      = 100,
  parameter int CP_Y1      = 140
`ifdef RACE_TIMEOUT_EN
  , parameter logic [15:0] MAX_RACE_CS = 16'd60000
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_pulse,
  input  logic        pause_pulse,
  input  logic [9:0]  p1_x,
  input  logic [9:0]  p1_y,
  input  logic [9:0]  p2_x,
  input  logic [9:0]  p2_y,
  output logic [2:0]  state,
  output logic [1:0]  countdown_val,
  output logic [1:0]  p1_lap,
  output logic [1:0]  p2_lap,
  output logic [1:0]  winner,
  output logic [15:0] race_time_cs,
  output logic [15:0] win_time_cs
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  state_t        state_q, state_d;
  logic [PW-1:0] presc;
  logic [7:0]    sub_cnt;
  logic          tick, sec_tick, go_ready, track_en;
  logic          p1_event, p2_event, p1_done, p2_done, timeout_hit;
  logic [1:0]    winner_d;
  logic [15:0]   time_d;

  assign state    = state_q;
  assign track_en = (state_q == RACING) || (state_q == FINISH);

  lap_tracker #(
    .LAPS(LAPS), .FIN_X0(FIN_X0), .FIN_X1(FIN_X1), .FIN_Y0(FIN_Y0), .FIN_Y1(FIN_Y1),
    .CP_X0(CP_X0), .CP_X1(CP_X1), .CP_Y0(CP_Y0), .CP_Y1(CP_Y1)
  ) u_lap_p1 (
    .clk(clk), .rst(rst), .enable(track_en), .clear(go_ready),
    .x(p1_x), .y(p1_y), .lap(p1_lap), .lap_event(p1_event)
  );

  lap_tracker #(
    .LAPS(LAPS), .FIN_X0(FIN_X0), .FIN_X1(FIN_X1), .FIN_Y0(FIN_Y0), .FIN_Y1(FIN_Y1),
    .CP_X0(CP_X0), .CP_X1(CP_X1), .CP_Y0(CP_Y0), .CP_Y1(CP_Y1)
  ) u_lap_p2 (
    .clk(clk), .rst(rst), .enable(track_en), .clear(go_ready),
    .x(p2_x), .y(p2_y), .lap(p2_lap), .lap_event(p2_event)
  );

  always_comb begin
    state_d     = state_q;
    go_ready    = 1'b0;
    timeout_hit = 1'b0;
    tick        = (presc == PW'(TICK_DIV - 1));
    sec_tick    = tick && (sub_cnt == 8'(CS_PER_SEC - 1));
    p1_done     = p1_event && (p1_lap == 2'(LAPS - 1));
    p2_done     = p2_event && (p2_lap == 2'(LAPS - 1));
    time_d      = race_time_cs;
    if ((state_q == RACING) && tick && (race_time_cs != 16'hFFFF))
      time_d = race_time_cs + 16'd1;
`ifdef RACE_TIMEOUT_EN
    timeout_hit = (state_q == RACING) && tick && (time_d == MAX_RACE_CS) &&
                  (race_time_cs != MAX_RACE_CS);
`endif

    // A real lap finish decides the winner; a timeout falls back to lap counts.
    if (p1_done && p2_done)  winner_d = WIN_TIE;
    else if (p1_done)        winner_d = WIN_P1;
    else if (p2_done)        winner_d = WIN_P2;
    else if (p1_lap > p2_lap) winner_d = WIN_P1;
    else if (p2_lap > p1_lap) winner_d = WIN_P2;
    else                     winner_d = WIN_TIE;

    case (state_q)
      MENU:      if (start_pulse) begin
                   state_d  = READY;
                   go_ready = 1'b1;
                 end
      READY:     if (tick && (sub_cnt == 8'(HOLD_TICKS - 1))) state_d = COUNTDOWN;
      COUNTDOWN: if (sec_tick && (countdown_val == 2'd1)) state_d = RACING;
      RACING:    if (p1_done || p2_done || timeout_hit) state_d = FINISH;
                 else if (pause_pulse)                  state_d = PAUSE;
      PAUSE:     if (pause_pulse) state_d = RACING;
      FINISH:    if (start_pulse) state_d = MENU;
      default:   state_d = MENU;
    endcase
  end

  // Prescaler and tick sub-counter restart on every state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= MENU;
      presc         <= '0;
      sub_cnt       <= '0;
      countdown_val <= '0;
      race_time_cs  <= '0;
      win_time_cs   <= '0;
      winner        <= WIN_NONE;
    end else begin
      state_q <= state_d;

      if (state_d != state_q) begin
        presc   <= '0;
        sub_cnt <= '0;
      end else if (tick) begin
        presc   <= '0;
        sub_cnt <= sec_tick ? 8'd0 : sub_cnt + 8'd1;
      end else begin
        presc <= presc + PW'(1);
      end

      if (state_d == COUNTDOWN)
        countdown_val <= (state_q != COUNTDOWN) ? 2'(COUNT_SEC) :
                         (sec_tick ? countdown_val - 2'd1 : countdown_val);
      else
        countdown_val <= '0;

      if (go_ready) begin
        race_time_cs <= '0;
        win_time_cs  <= '0;
        winner       <= WIN_NONE;
      end else begin
        race_time_cs <= time_d;
        if ((state_q == RACING) && (state_d == FINISH)) begin
          winner      <= winner_d;
          win_time_cs <= time_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_race_controller.sv
// Directed testbench for race_controller with short tick/hold parameters.
// Build with RACE_TIMEOUT_EN defined to exercise the timeout path instead of pause.
module tb_race_controller;

  logic        clk;
  logic        rst;
  logic        start_pulse;
  logic        pause_pulse;
  logic [9:0]  p1_x, p1_y, p2_x, p2_y;
  logic [2:0]  state;
  logic [1:0]  countdown_val;
  logic [1:0]  p1_lap, p2_lap;
  logic [1:0]  winner;
  logic [15:0] race_time_cs;
  logic [15:0] win_time_cs;

  int errors = 0;
  int checks = 0;

  race_controller #(
    .TICK_DIV(4), .LAPS(3), .HOLD_TICKS(2), .COUNT_SEC(3)
`ifdef RACE_TIMEOUT_EN
    , .MAX_RACE_CS(16'd20)
`endif
  ) dut (
    .clk(clk), .rst(rst), .start_pulse(start_pulse), .pause_pulse(pause_pulse),
    .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
    .state(state), .countdown_val(countdown_val), .p1_lap(p1_lap), .p2_lap(p2_lap),
    .winner(winner), .race_time_cs(race_time_cs), .win_time_cs(win_time_cs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulseStart();
    start_pulse = 1'b1;
    step(1);
    start_pulse = 1'b0;
  endtask

  task automatic pulsePause();
    pause_pulse = 1'b1;
    step(1);
    pause_pulse = 1'b0;
  endtask

  // Zone positions: grid/finish, checkpoint, and open track.
  task automatic applyStimulus(input int who, input int zone);
    logic [9:0] x, y;
    case (zone)
      0:       begin x = 10'd20;  y = 10'd125; end
      1:       begin x = 10'd280; y = 10'd120; end
      default: begin x = 10'd150; y = 10'd50;  end
    endcase
    if (who == 1 || who == 3) begin p1_x = x; p1_y = y; end
    if (who == 2 || who == 3) begin p2_x = x; p2_y = y; end
  endtask

  task automatic lapMove(input int who);
    applyStimulus(who, 2); step(1);
    applyStimulus(who, 1); step(1);
    applyStimulus(who, 0); step(1);
  endtask

  initial begin
    rst = 1'b1; start_pulse = 1'b0; pause_pulse = 1'b0;
    applyStimulus(3, 0);
    step(2);
    rst = 1'b0;
    checkOutput("reset_state", 16'(state), 16'd0);
    checkOutput("reset_cd", 16'(countdown_val), 16'd0);
    checkOutput("reset_laps", 16'({p1_lap, p2_lap}), 16'd0);
    checkOutput("reset_winner", 16'(winner), 16'd0);
    checkOutput("reset_time", race_time_cs, 16'd0);
    checkOutput("reset_wintime", win_time_cs, 16'd0);

    pulsePause();
    checkOutput("pause_in_menu", 16'(state), 16'd0);

    // Start sequence: READY 8 cycles, then 3,2,1 countdown of 400 cycles each.
    pulseStart();
    checkOutput("ready_entry", 16'(state), 16'd1);
    step(7);
    checkOutput("ready_c7", 16'(state), 16'd1);
    step(1);
    checkOutput("cd_entry_state", 16'(state), 16'd2);
    checkOutput("cd_entry_val", 16'(countdown_val), 16'd3);
    pulseStart();
    checkOutput("start_in_cd", 16'(state), 16'd2);
    step(398);
    checkOutput("cd_c407", 16'(countdown_val), 16'd3);
    step(1);
    checkOutput("cd_c408", 16'(countdown_val), 16'd2);
    step(400);
    checkOutput("cd_c808", 16'(countdown_val), 16'd1);
    step(399);
    checkOutput("cd_c1207", 16'(state), 16'd2);
    step(1);
    checkOutput("race_c1208", 16'(state), 16'd4);
    checkOutput("race_cd0", 16'(countdown_val), 16'd0);

    // Finish toggle without checkpoint must not count.
    applyStimulus(1, 2); step(1);
    applyStimulus(1, 0); step(1);
    checkOutput("no_cp_lap", 16'(p1_lap), 16'd0);
    applyStimulus(1, 2); step(1);
    applyStimulus(1, 1); step(1);
    applyStimulus(1, 0); step(1);
    checkOutput("p1_lap1", 16'(p1_lap), 16'd1);
    lapMove(1);
    checkOutput("p1_lap2", 16'(p1_lap), 16'd2);
    lapMove(1);
    checkOutput("p1_fin_state", 16'(state), 16'd5);
    checkOutput("p1_fin_lap", 16'(p1_lap), 16'd3);
    checkOutput("p1_fin_winner", 16'(winner), 16'd1);
    checkOutput("p1_fin_wintime", win_time_cs, 16'd2);
    checkOutput("p1_fin_time", race_time_cs, 16'd2);
    lapMove(2);
    step(8);
    checkOutput("trail_p2_lap", 16'(p2_lap), 16'd1);
    checkOutput("trail_winner", 16'(winner), 16'd1);
    checkOutput("finish_time_frozen", race_time_cs, 16'd2);

    // Simultaneous finish.
    pulseStart();
    checkOutput("finish_to_menu", 16'(state), 16'd0);
    pulseStart();
    checkOutput("clear_laps", 16'({p1_lap, p2_lap}), 16'd0);
    checkOutput("clear_winner", 16'(winner), 16'd0);
    checkOutput("clear_wintime", win_time_cs, 16'd0);
    step(1208);
    checkOutput("race2_state", 16'(state), 16'd4);
    lapMove(3); lapMove(3); lapMove(3);
    checkOutput("tie_state", 16'(state), 16'd5);
    checkOutput("tie_winner", 16'(winner), 16'd3);
    checkOutput("tie_wintime", win_time_cs, 16'd2);

    // Reset mid-race.
    pulseStart();
    pulseStart();
    step(1208);
    lapMove(1);
    step(4);
    checkOutput("pre_rst_lap", 16'(p1_lap), 16'd1);
    checkOutput("pre_rst_time", race_time_cs, 16'd1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checkOutput("rst_state", 16'(state), 16'd0);
    checkOutput("rst_lap", 16'(p1_lap), 16'd0);
    checkOutput("rst_time", race_time_cs, 16'd0);
    checkOutput("rst_winner", 16'(winner), 16'd0);

    pulseStart();
    step(1208);
    checkOutput("race3_state", 16'(state), 16'd4);
`ifndef RACE_TIMEOUT_EN
    // Pause freezes timer and lap tracking.
    step(200);
    checkOutput("pre_pause_time", race_time_cs, 16'd50);
    pulsePause();
    checkOutput("pause_state", 16'(state), 16'd3);
    applyStimulus(2, 1); step(10);
    applyStimulus(2, 2); step(10);
    applyStimulus(2, 0); step(1980);
    checkOutput("paused_time", race_time_cs, 16'd50);
    checkOutput("paused_p2_lap", 16'(p2_lap), 16'd0);
    pulsePause();
    checkOutput("resume_state", 16'(state), 16'd4);
    step(3);
    checkOutput("resume_c3", race_time_cs, 16'd50);
    step(1);
    checkOutput("resume_c4", race_time_cs, 16'd51);
    checkOutput("resume_p2_lap", 16'(p2_lap), 16'd0);
`else
    // Timeout at 20 centiseconds with P1 one lap ahead.
    lapMove(1);
    checkOutput("to_p1_lap", 16'(p1_lap), 16'd1);
    step(76);
    checkOutput("to_c79_state", 16'(state), 16'd4);
    checkOutput("to_c79_time", race_time_cs, 16'd19);
    step(1);
    checkOutput("to_state", 16'(state), 16'd5);
    checkOutput("to_winner", 16'(winner), 16'd1);
    checkOutput("to_wintime", win_time_cs, 16'd20);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
